// File: rtl/image_mem_arbiter.sv
// rtl/image_mem_arbiter.sv - image RAM arbiter between a CPU port and a display prefetch FIFO.
module image_mem_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int LOW_WATER    = 2,
  parameter int FRAME_PIXELS = 307200,
  parameter int MAX_CONSEC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_frame_start,
  input  logic              disp_pop,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_pixel,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LVL_W  = CNT_W + 1;
  localparam int CONS_W = $clog2(MAX_CONSEC + 1);
  localparam int SCAN_W = ADDR_W + 1;

  localparam logic [LVL_W-1:0]  LOW_LVL   = LVL_W'(LOW_WATER);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [SCAN_W-1:0] FRAME_LIM = SCAN_W'(FRAME_PIXELS);
  localparam logic [CONS_W-1:0] CONS_LIM  = CONS_W'(MAX_CONSEC);

  typedef enum logic [2:0] {IDLE, CPU_WR, CPU_RD, CPU_CAP, DISP_RD, DISP_CAP} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [SCAN_W-1:0]   scan_adr;
  logic [CONS_W-1:0]   consec;
  logic [DATA_W-1:0]   rdata_q;
  logic                drop;
  logic                inflight, scan_more, urgent, room;
  logic                grant_cpu, grant_disp, push, pop;
  logic [LVL_W-1:0]    level;

  assign inflight  = (state == DISP_RD) || (state == DISP_CAP);
  assign level     = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign scan_more = scan_adr < FRAME_LIM;
  // A frame restart in IDLE blocks display grants so scan_adr has a single writer that edge.
  assign urgent    = (level <= LOW_LVL) && scan_more && (consec < CONS_LIM) && !disp_frame_start;
  assign room      = (level < FULL_LVL) && scan_more && !disp_frame_start;

  assign push       = (state == DISP_CAP) && !disp_frame_start && !drop;
  assign pop        = disp_pop && disp_valid && !disp_frame_start;
  assign disp_valid = (fifo_count != '0);
  assign disp_pixel = disp_valid ? fifo_mem[rd_ptr] : '0;
  assign cpu_rdata  = (state == CPU_CAP) ? ram_q : rdata_q;

  always_comb begin
    state_nxt  = state;
    grant_cpu  = 1'b0;
    grant_disp = 1'b0;
    case (state)
      IDLE: begin
        if (urgent) begin
          grant_disp = 1'b1;
          state_nxt  = DISP_RD;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          state_nxt = cpu_we ? CPU_WR : CPU_RD;
        end else if (room) begin
          grant_disp = 1'b1;
          state_nxt  = DISP_RD;
        end
      end
      CPU_WR:   state_nxt = IDLE;
      CPU_RD:   state_nxt = CPU_CAP;
      CPU_CAP:  state_nxt = IDLE;
      DISP_RD:  state_nxt = DISP_CAP;
      DISP_CAP: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cpu_ack    <= 1'b0;
      ram_wren   <= 1'b0;
      ram_adr    <= '0;
      ram_wdata  <= '0;
      rdata_q    <= '0;
      scan_adr   <= '0;
      consec     <= '0;
      drop       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state    <= state_nxt;
      cpu_ack  <= (state_nxt == CPU_WR) || (state_nxt == CPU_CAP);
      ram_wren <= (state_nxt == CPU_WR);

      if (grant_cpu) begin
        ram_adr <= cpu_adr;
        if (cpu_we) ram_wdata <= cpu_wdata;
      end
      if (grant_disp) begin
        ram_adr  <= scan_adr[ADDR_W-1:0];
        scan_adr <= scan_adr + 1'b1;
      end
      if (disp_frame_start) scan_adr <= '0;

      if (state == IDLE) begin
        if (grant_cpu || !cpu_req) consec <= '0;
        else if (grant_disp)       consec <= consec + 1'b1;
      end

      if (state == CPU_CAP) rdata_q <= ram_q;

      // A read issued before a frame restart belongs to the old frame; drop its capture too.
      if (disp_frame_start && state == DISP_RD) drop <= 1'b1;
      else if (state == DISP_CAP)               drop <= 1'b0;

      if (disp_frame_start) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_q;
  end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// tb/tb_image_mem_arbiter.sv - directed bench for image_mem_arbiter with a registered RAM model.
module tb_image_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [18:0] cpu_adr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        disp_frame_start, disp_pop, disp_valid;
  logic [7:0]  disp_pixel;
  logic [18:0] ram_adr;
  logic [7:0]  ram_wdata;
  logic        ram_wren;
  logic [7:0]  ram_q;

  logic [7:0]  ram [256];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_idx;

  always #5 clk = ~clk;

  image_mem_arbiter #(.FRAME_PIXELS(20)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .disp_frame_start(disp_frame_start), .disp_pop(disp_pop),
    .disp_valid(disp_valid), .disp_pixel(disp_pixel),
    .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (ram_wren) ram[ram_adr[7:0]] <= ram_wdata;
    ram_q <= ram[ram_adr[7:0]];
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_cpu(input logic we, input logic [18:0] adr, input logic [7:0] wd,
                        input logic [7:0] exp, input int lat, input int bound);
    int  n;
    bit  got;
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
    n = 0; got = 1'b0;
    while (!got && n < bound) begin
      @(negedge clk);
      n++;
      if (cpu_ack) got = 1'b1;
    end
    check(got, "cpu_ack_timeout", 32'(got), 32'd1);
    if (lat > 0) check(n == lat, "cpu_ack_latency", 32'(n), 32'(lat));
    if (we) begin
      check(ram_wren == 1'b1, "wr_wren", 32'(ram_wren), 32'd1);
      check(ram_adr == adr, "wr_adr", 32'(ram_adr), 32'(adr));
      check(ram_wdata == wd, "wr_wdata", 32'(ram_wdata), 32'(wd));
    end else begin
      check(cpu_rdata == exp, "rd_data", 32'(cpu_rdata), 32'(exp));
    end
    cpu_req = 1'b0;
    @(negedge clk);
    check(!cpu_ack && !ram_wren, "ack_one_cycle", {30'd0, cpu_ack, ram_wren}, 32'd0);
    if (!we) check(cpu_rdata == exp, "rd_data_hold", 32'(cpu_rdata), 32'(exp));
  endtask

  task automatic pop_step();
    if (disp_valid) begin
      check(disp_pixel == 8'(exp_idx), "pixel_order", 32'(disp_pixel), 32'(exp_idx));
      exp_idx++;
      disp_pop = 1'b1;
    end else begin
      disp_pop = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({cpu_ack, ram_wren, disp_valid} == 3'b000, name, {29'd0, cpu_ack, ram_wren, disp_valid}, 32'd0);
    check(cpu_rdata == 8'd0 && disp_pixel == 8'd0, name, {16'd0, cpu_rdata, disp_pixel}, 32'd0);
    check(ram_adr == 19'd0 && ram_wdata == 8'd0, name, {5'd0, ram_adr, ram_wdata}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [18:0] adr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    int          lat;
  } cpu_vec_t;

  cpu_vec_t vecs [6];

  initial begin
    int n;
    int seen;
    vecs[0] = '{1'b1, 19'h00010, 8'hA5, 8'h00, 1};
    vecs[1] = '{1'b0, 19'h00020, 8'h00, 8'h3C, 2};
    vecs[2] = '{1'b0, 19'h00010, 8'h00, 8'hA5, 2};
    vecs[3] = '{1'b1, 19'h00033, 8'h5A, 8'h00, 1};
    vecs[4] = '{1'b0, 19'h00033, 8'h00, 8'h5A, 2};
    vecs[5] = '{1'b1, 19'h00010, 8'h10, 8'h00, 1};

    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    ram[8'h20] = 8'h3C;
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    disp_frame_start = 1'b0; disp_pop = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");

    reset = 1'b1;
    repeat (40) @(negedge clk);
    check(disp_valid == 1'b1, "prefetch_valid", 32'(disp_valid), 32'd1);
    check(disp_pixel == 8'h00, "prefetch_head", 32'(disp_pixel), 32'd0);
    check(ram_adr == 19'd7, "prefetch_last_adr", 32'(ram_adr), 32'd7);

    for (int i = 0; i < 6; i++)
      do_cpu(vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].lat, 10);

    for (int i = 0; i < 8; i++) begin
      check(disp_valid && disp_pixel == 8'(i), "fifo_pop_order", 32'(disp_pixel), 32'(i));
      disp_pop = 1'b1;
      @(negedge clk);
    end
    disp_pop = 1'b0;

    disp_frame_start = 1'b1;
    @(negedge clk);
    disp_frame_start = 1'b0;
    check(disp_valid == 1'b0, "frame_start_flush", 32'(disp_valid), 32'd0);
    exp_idx = 0;
    fork
      begin
        do_cpu(1'b0, 19'h00020, 8'h00, 8'h3C, 0, 20);
        do_cpu(1'b0, 19'h00005, 8'h00, 8'h05, 0, 20);
        do_cpu(1'b0, 19'h00033, 8'h00, 8'h5A, 0, 20);
        do_cpu(1'b0, 19'h00010, 8'h00, 8'h10, 0, 20);
      end
      begin
        repeat (60) pop_step();
      end
    join

    n = 0;
    while (exp_idx < 20 && n < 150) begin
      pop_step();
      n++;
    end
    disp_pop = 1'b0;
    check(exp_idx == 20, "frame_pixel_count", 32'(exp_idx), 32'd20);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (disp_valid) seen++;
    end
    check(seen == 0, "scan_stops_at_frame_end", 32'(seen), 32'd0);
    check(ram_adr == 19'd19, "last_scan_adr", 32'(ram_adr), 32'd19);

    disp_frame_start = 1'b1;
    @(negedge clk);
    disp_frame_start = 1'b0;
    repeat (40) @(negedge clk);
    check(disp_valid && disp_pixel == 8'h00, "refill_head", 32'(disp_pixel), 32'd0);
    disp_pop = 1'b1;
    @(negedge clk);
    disp_pop = 1'b0;
    @(negedge clk);
    check(ram_adr == 19'd8, "refill_issue_adr", 32'(ram_adr), 32'd8);
    @(negedge clk);
    disp_frame_start = 1'b1;
    @(negedge clk);
    disp_frame_start = 1'b0;
    check(disp_valid == 1'b0 && disp_pixel == 8'h00, "flush_during_cap", 32'(disp_valid), 32'd0);
    n = 0;
    while (ram_adr == 19'd8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(ram_adr == 19'd0, "restart_adr_zero", 32'(ram_adr), 32'd0);
    repeat (8) @(negedge clk);
    check(disp_valid && disp_pixel == 8'h00, "restart_head", 32'(disp_pixel), 32'd0);

    repeat (40) @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 19'h00020;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_in_cpu_cap");
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_ack) seen++;
    end
    check(seen == 0, "no_ack_after_abort", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
